// File: rtl/ex_mem_skid_reg_if.sv
// EX->MEM handshake bundle: producer-side entry fields and consumer-side registered fields.
interface ex_mem_skid_reg_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_rd2;
  logic [XLEN-1:0] in_adder_out;
  logic [XLEN-1:0] in_pc_plus4;
  logic [RAW-1:0]  in_rd;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_alu_result;
  logic [XLEN-1:0] out_rd2;
  logic [XLEN-1:0] out_adder_out;
  logic [XLEN-1:0] out_pc_plus4;
  logic [RAW-1:0]  out_rd;

  modport slave (
    input  in_valid, in_alu_result, in_rd2, in_adder_out, in_pc_plus4, in_rd,
    output in_ready,
    output out_valid, out_alu_result, out_rd2, out_adder_out, out_pc_plus4, out_rd,
    input  out_ready
  );

  modport master (
    output in_valid, in_alu_result, in_rd2, in_adder_out, in_pc_plus4, in_rd,
    input  in_ready,
    input  out_valid, out_alu_result, out_rd2, out_adder_out, out_pc_plus4, out_rd,
    output out_ready
  );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with one skid entry so in_ready is fully registered,
// plus a saturating back-pressure cycle counter.
module ex_mem_skid_reg #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  ex_mem_skid_reg_if.slave    bus,
  output logic [CNTW-1:0]     stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] adder_out;
    logic [XLEN-1:0] pc_plus4;
    logic [RAW-1:0]  rd;
  } entry_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  state_e          state_q, state_d;
  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [CNTW-1:0] stall_q, stall_d;

  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = '{alu_result: bus.in_alu_result, rd2: bus.in_rd2,
                      adder_out: bus.in_adder_out, pc_plus4: bus.in_pc_plus4,
                      rd: bus.in_rd};
  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;

  // Occupancy transitions; flush overrides everything and leaves data stale.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = in_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_entry;
        end else if (in_fire) begin
          skid_d  = in_entry;
          state_d = ST_TWO;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    if (out_valid_q && !bus.out_ready && !flush && (stall_q != {CNTW{1'b1}})) begin
      stall_d = stall_q + CNTW'(1);
    end

    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_alu_result = main_q.alu_result;
  assign bus.out_rd2        = main_q.rd2;
  assign bus.out_adder_out  = main_q.adder_out;
  assign bus.out_pc_plus4   = main_q.pc_plus4;
  assign bus.out_rd         = main_q.rd;
  assign stall_cnt          = stall_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg: directed scenarios, a CNTW=4 saturation
// instance, and a long random valid/ready run.
module tb_ex_mem_skid_reg;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rd2;
    logic [31:0] adder_out;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } tb_entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_s;

  ex_mem_skid_reg_if #(.XLEN(32), .RAW(5)) bus ();
  ex_mem_skid_reg_if #(.XLEN(32), .RAW(5)) bus_s ();

  ex_mem_skid_reg #(.XLEN(32), .RAW(5), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .stall_cnt(stall_cnt)
  );

  ex_mem_skid_reg #(.XLEN(32), .RAW(5), .CNTW(4)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_s), .stall_cnt(stall_cnt_s)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  tb_entry_t   q[$];
  logic [15:0] exp_stall = '0;
  bit          probe_comb = 1'b0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic tb_entry_t mk(input int unsigned v);
    tb_entry_t e;
    e.alu_result = v;
    e.rd2        = 32'h1000_0000 ^ v;
    e.adder_out  = 32'h2000_0000 + v;
    e.pc_plus4   = 32'h3000_0000 | (v << 2);
    e.rd         = 5'(v);
    return e;
  endfunction

  task automatic drive_in(input bit valid, input tb_entry_t e);
    bus.in_valid      = valid;
    bus.in_alu_result = e.alu_result;
    bus.in_rd2        = e.rd2;
    bus.in_adder_out  = e.adder_out;
    bus.in_pc_plus4   = e.pc_plus4;
    bus.in_rd         = e.rd;
  endtask

  // One clock: compare DUT against the model, advance the model, cross the edge.
  task automatic tick(output bit accepted);
    tb_entry_t got;
    bit        mv;
    bit        in_fire;
    bit        out_fire;
    logic      rdy0;
    #2;
    mv = (q.size() != 0);
    check("out_valid", 160'(bus.out_valid), 160'(mv));
    check("in_ready", 160'(bus.in_ready), 160'(q.size() < 2));
    check("stall_cnt", 160'(stall_cnt), 160'(exp_stall));
    if (mv) begin
      got = '{bus.out_alu_result, bus.out_rd2, bus.out_adder_out, bus.out_pc_plus4, bus.out_rd};
      check("out_entry", 160'(got), 160'(q[0]));
    end
    if (probe_comb) begin
      rdy0 = bus.in_ready;
      bus.out_ready = ~bus.out_ready;
      #1;
      check("in_ready_comb", 160'(bus.in_ready), 160'(rdy0));
      bus.out_ready = ~bus.out_ready;
      #1;
    end
    in_fire  = bus.in_valid && (q.size() < 2);
    out_fire = mv && bus.out_ready;
    accepted = in_fire && !rst && !flush;
    if (rst) begin
      q.delete();
      exp_stall = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (mv && !bus.out_ready && exp_stall != 16'hFFFF) exp_stall++;
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back('{bus.in_alu_result, bus.in_rd2, bus.in_adder_out,
                                 bus.in_pc_plus4, bus.in_rd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input tb_entry_t e);
    bit acc;
    drive_in(1'b1, e);
    for (int i = 0; i < 50; i++) begin
      tick(acc);
      if (acc) break;
    end
    if (!acc) check("send_timeout", 160'(0), 160'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  initial begin
    bit acc;
    rst = 1'b1;
    flush = 1'b0;
    drive_in(1'b0, mk(0));
    bus.out_ready = 1'b1;
    bus_s.in_valid = 1'b0;
    bus_s.in_alu_result = '0;
    bus_s.in_rd2 = '0;
    bus_s.in_adder_out = '0;
    bus_s.in_pc_plus4 = '0;
    bus_s.in_rd = '0;
    bus_s.out_ready = 1'b0;
    @(posedge clk);
    #1;
    idle(1);
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", 160'(bus.out_valid), 160'(0));
    check("rst_in_ready", 160'(bus.in_ready), 160'(1));
    check("rst_stall", 160'(stall_cnt), 160'(0));
    check("rst_alu", 160'(bus.out_alu_result), 160'(0));

    // Streaming, one-cycle latency, no stalls
    for (int i = 1; i <= 8; i++) send(mk(i));
    idle(2);
    check("stream_stall", 160'(stall_cnt), 160'(0));

    // Back-pressure: A, B fill both slots, C is held off
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    send(mk(32'hA));
    send(mk(32'hB));
    drive_in(1'b1, mk(32'hC));
    idle(3);
    check("bp_in_ready_low", 160'(bus.in_ready), 160'(0));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(acc);
      if (acc) break;
    end
    bus.in_valid = 1'b0;
    idle(4);
    check("bp_stall_total", 160'(stall_cnt), 160'(4));

    // Flush while TWO with a new offer in the same cycle
    bus.out_ready = 1'b0;
    send(mk(32'h11));
    send(mk(32'h12));
    flush = 1'b1;
    drive_in(1'b1, mk(32'h13));
    idle(1);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 160'(bus.out_valid), 160'(0));
    check("flush_in_ready", 160'(bus.in_ready), 160'(1));
    bus.out_ready = 1'b1;
    idle(3);

    // Saturation on the CNTW=4 instance
    bus_s.in_valid = 1'b1;
    bus_s.in_alu_result = 32'h55;
    idle(1);
    bus_s.in_valid = 1'b0;
    idle(14);
    check("sat_14", 160'(stall_cnt_s), 160'(14));
    idle(6);
    check("sat_hold_15", 160'(stall_cnt_s), 160'(15));
    check("sat_out_valid", 160'(bus_s.out_valid), 160'(1));

    // Reset with flush while TWO
    bus.out_ready = 1'b0;
    send(mk(32'h21));
    send(mk(32'h22));
    rst = 1'b1;
    flush = 1'b1;
    idle(1);
    rst = 1'b0;
    flush = 1'b0;
    check("mid_rst_out_valid", 160'(bus.out_valid), 160'(0));
    check("mid_rst_in_ready", 160'(bus.in_ready), 160'(1));
    check("mid_rst_alu", 160'(bus.out_alu_result), 160'(0));
    check("mid_rst_stall", 160'(stall_cnt), 160'(0));

    // Random valid/ready with occasional flush
    probe_comb = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      tb_entry_t e;
      e = '{$urandom(), $urandom(), $urandom(), $urandom(), 5'($urandom())};
      if (!bus.in_valid || acc) drive_in($urandom_range(0, 3) != 0, e);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 99) == 0);
      tick(acc);
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    probe_comb = 1'b0;
    idle(3);
    check("drain_empty", 160'(bus.out_valid), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
